// File: rtl/alu_system_controller_if.sv
// Control/status bundle between the ALU system sequencer (master) and its datapath (slave).
// mem_ready is present only when CTRL_MEM_WAIT_EN is defined.
interface alu_system_controller_if;
   logic [15:0] ir_out;
   logic [3:0]  alu_flags;
   logic [2:0]  rf_out_a_sel;
   logic [2:0]  rf_out_b_sel;
   logic [2:0]  rf_fun_sel;
   logic [3:0]  rf_reg_sel;
   logic [3:0]  rf_scr_sel;
   logic [4:0]  alu_fun_sel;
   logic [1:0]  arf_out_c_sel;
   logic [1:0]  arf_out_d_sel;
   logic [2:0]  arf_fun_sel;
   logic [2:0]  arf_reg_sel;
   logic        ir_lh;
   logic        ir_write;
   logic        mem_cs;
   logic        mem_wr;
   logic        alu_wf;
   logic        mux_c_sel;
   logic [1:0]  mux_a_sel;
   logic [1:0]  mux_b_sel;
`ifdef CTRL_MEM_WAIT_EN
   logic        mem_ready;
`endif

   modport master (
      input  ir_out, alu_flags,
`ifdef CTRL_MEM_WAIT_EN
      input  mem_ready,
`endif
      output rf_out_a_sel, rf_out_b_sel, rf_fun_sel, rf_reg_sel, rf_scr_sel, alu_fun_sel,
      output arf_out_c_sel, arf_out_d_sel, arf_fun_sel, arf_reg_sel,
      output ir_lh, ir_write, mem_cs, mem_wr, alu_wf, mux_c_sel, mux_a_sel, mux_b_sel
   );

   modport slave (
      output ir_out, alu_flags,
`ifdef CTRL_MEM_WAIT_EN
      output mem_ready,
`endif
      input  rf_out_a_sel, rf_out_b_sel, rf_fun_sel, rf_reg_sel, rf_scr_sel, alu_fun_sel,
      input  arf_out_c_sel, arf_out_d_sel, arf_fun_sel, arf_reg_sel,
      input  ir_lh, ir_write, mem_cs, mem_wr, alu_wf, mux_c_sel, mux_a_sel, mux_b_sel
   );
endinterface

// File: rtl/alu_system_controller.sv
// ALU system sequencer: two-byte fetch, decode, 1-2 execute cycles (3 cycles/instr, PUSH 4).
// No backpressure by default; with CTRL_MEM_WAIT_EN, memory states stall while mem_ready is low.
module alu_system_controller #(
   parameter bit         REGSEL_ACTIVE_LOW = 1'b1,
   parameter logic [2:0] FUN_HOLD  = 3'b000,
   parameter logic [2:0] FUN_CLEAR = 3'b011,
   parameter logic [2:0] FUN_LOAD  = 3'b010,
   parameter logic [2:0] FUN_INC   = 3'b001,
   parameter logic [2:0] FUN_DEC   = 3'b100,
   parameter logic [4:0] ALU_PASSA = 5'h10,
   parameter logic [4:0] ALU_ADD   = 5'h14,
   parameter logic [4:0] ALU_SUB   = 5'h16,
   parameter logic [4:0] ALU_AND   = 5'h17,
   parameter logic [4:0] ALU_OR    = 5'h18
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   alu_system_controller_if.master         io_dp,
   output logic [2:0]                      o_seq_state,
   output logic                            o_halted
);
   typedef enum logic [2:0] {
      S_INIT    = 3'd0,
      S_FETCH_L = 3'd1,
      S_FETCH_H = 3'd2,
      S_EXEC1   = 3'd3,
      S_EXEC2   = 3'd4,
      S_HALT    = 3'd5
   } state_t;

   localparam logic [3:0] OP_LDIM = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4, OP_LD  = 4'h5, OP_ST  = 4'h6, OP_LDAR = 4'h7;
   localparam logic [3:0] OP_BRA  = 4'h8, OP_BEQ = 4'h9, OP_PUSH = 4'hA, OP_HLT = 4'hF;
   localparam logic [1:0] ARF_PC = 2'd0, ARF_AR = 2'd1, ARF_SP = 2'd2;

   state_t      r_state, w_next;
   logic [3:0]  w_op;
   logic [1:0]  w_rd;
   logic [2:0]  w_ra, w_rb;
   logic [3:0]  w_rd_en;
   logic [2:0]  w_rf_a, w_rf_b, w_rf_fun, w_arf_fun, w_arf_en;
   logic [3:0]  w_rf_en, w_scr_en;
   logic [4:0]  w_alu_fun;
   logic [1:0]  w_arf_c, w_arf_d, w_mux_a, w_mux_b;
   logic        w_ir_lh, w_ir_write, w_mem_cs, w_mem_wr, w_alu_wf, w_mux_c, w_mem_stage;
   logic        w_unused_bits;

   assign w_op    = io_dp.ir_out[15:12];
   assign w_rd    = io_dp.ir_out[11:10];
   assign w_ra    = io_dp.ir_out[9:7];
   assign w_rb    = io_dp.ir_out[6:4];
   assign w_rd_en = 4'b1000 >> w_rd;
   assign w_unused_bits = ^{io_dp.ir_out[3:0], io_dp.alu_flags[2:0]};

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_INIT;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_rf_a      = 3'd0;
      w_rf_b      = 3'd0;
      w_rf_fun    = FUN_HOLD;
      w_rf_en     = 4'b0000;
      w_scr_en    = 4'b0000;
      w_alu_fun   = 5'd0;
      w_arf_c     = 2'd0;
      w_arf_d     = 2'd0;
      w_arf_fun   = FUN_HOLD;
      w_arf_en    = 3'b000;
      w_ir_lh     = 1'b0;
      w_ir_write  = 1'b0;
      w_mem_cs    = 1'b1;
      w_mem_wr    = 1'b0;
      w_alu_wf    = 1'b0;
      w_mux_c     = 1'b0;
      w_mux_a     = 2'd0;
      w_mux_b     = 2'd0;
      w_mem_stage = 1'b0;
      if (i_rst) begin
         w_next = S_INIT;
      end else begin
         case (r_state)
            S_INIT: begin
               w_rf_fun  = FUN_CLEAR;
               w_rf_en   = 4'b1111;
               w_scr_en  = 4'b1111;
               w_arf_fun = FUN_CLEAR;
               w_arf_en  = 3'b111;
               w_next    = S_FETCH_L;
            end
            S_FETCH_L, S_FETCH_H: begin
               w_arf_d     = ARF_PC;
               w_mem_cs    = 1'b0;
               w_ir_write  = 1'b1;
               w_ir_lh     = (r_state == S_FETCH_H);
               w_arf_fun   = FUN_INC;
               w_arf_en    = 3'b100;
               w_mem_stage = 1'b1;
               w_next      = (r_state == S_FETCH_L) ? S_FETCH_H : S_EXEC1;
            end
            S_EXEC1: begin
               w_next = S_FETCH_L;
               case (w_op)
                  OP_LDIM: begin
                     w_mux_a  = 2'b11;
                     w_rf_fun = FUN_LOAD;
                     w_rf_en  = w_rd_en;
                  end
                  OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                     w_rf_a   = w_ra;
                     w_rf_b   = w_rb;
                     w_alu_wf = 1'b1;
                     w_rf_fun = FUN_LOAD;
                     w_rf_en  = w_rd_en;
                     case (w_op)
                        OP_ADD:  w_alu_fun = ALU_ADD;
                        OP_SUB:  w_alu_fun = ALU_SUB;
                        OP_AND:  w_alu_fun = ALU_AND;
                        default: w_alu_fun = ALU_OR;
                     endcase
                  end
                  OP_LD: begin
                     w_arf_d     = ARF_AR;
                     w_mem_cs    = 1'b0;
                     w_mux_a     = 2'b10;
                     w_rf_fun    = FUN_LOAD;
                     w_rf_en     = w_rd_en;
                     w_mem_stage = 1'b1;
                  end
                  OP_ST: begin
                     w_rf_a      = w_ra;
                     w_alu_fun   = ALU_PASSA;
                     w_arf_d     = ARF_AR;
                     w_mem_cs    = 1'b0;
                     w_mem_wr    = 1'b1;
                     w_mem_stage = 1'b1;
                  end
                  OP_LDAR: begin
                     w_mux_b   = 2'b11;
                     w_arf_fun = FUN_LOAD;
                     w_arf_en  = 3'b010;
                  end
                  OP_BRA, OP_BEQ: begin
                     // BEQ falls through with no writes when Z is clear
                     if (w_op == OP_BRA || io_dp.alu_flags[3]) begin
                        w_mux_b   = 2'b11;
                        w_arf_fun = FUN_LOAD;
                        w_arf_en  = 3'b100;
                     end
                  end
                  OP_PUSH: begin
                     w_arf_fun = FUN_DEC;
                     w_arf_en  = 3'b001;
                     w_next    = S_EXEC2;
                  end
                  OP_HLT:  w_next = S_HALT;
                  default: ;
               endcase
            end
            S_EXEC2: begin
               w_rf_a      = w_ra;
               w_alu_fun   = ALU_PASSA;
               w_arf_d     = ARF_SP;
               w_mem_cs    = 1'b0;
               w_mem_wr    = 1'b1;
               w_mem_stage = 1'b1;
               w_next      = S_FETCH_L;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_INIT;
         endcase
`ifdef CTRL_MEM_WAIT_EN
         // Memory not ready: hold the state, keep address/CS, suppress every write side-effect
         if (w_mem_stage && !io_dp.mem_ready) begin
            w_next     = r_state;
            w_ir_write = 1'b0;
            w_mem_wr   = 1'b0;
            w_rf_en    = 4'b0000;
            w_scr_en   = 4'b0000;
            w_arf_en   = 3'b000;
         end
`endif
      end
   end

   assign io_dp.rf_out_a_sel  = w_rf_a;
   assign io_dp.rf_out_b_sel  = w_rf_b;
   assign io_dp.rf_fun_sel    = w_rf_fun;
   assign io_dp.rf_reg_sel    = REGSEL_ACTIVE_LOW ? ~w_rf_en  : w_rf_en;
   assign io_dp.rf_scr_sel    = REGSEL_ACTIVE_LOW ? ~w_scr_en : w_scr_en;
   assign io_dp.alu_fun_sel   = w_alu_fun;
   assign io_dp.arf_out_c_sel = w_arf_c;
   assign io_dp.arf_out_d_sel = w_arf_d;
   assign io_dp.arf_fun_sel   = w_arf_fun;
   assign io_dp.arf_reg_sel   = REGSEL_ACTIVE_LOW ? ~w_arf_en : w_arf_en;
   assign io_dp.ir_lh         = w_ir_lh;
   assign io_dp.ir_write      = w_ir_write;
   assign io_dp.mem_cs        = w_mem_cs;
   assign io_dp.mem_wr        = w_mem_wr;
   assign io_dp.alu_wf        = w_alu_wf;
   assign io_dp.mux_c_sel     = w_mux_c;
   assign io_dp.mux_a_sel     = w_mux_a;
   assign io_dp.mux_b_sel     = w_mux_b;
   assign o_seq_state         = r_state;
   assign o_halted            = (r_state == S_HALT);
endmodule
